// File: rtl/dmem_pkg.sv
// dmem_ctrl shared types: funct3 codes, FSM states, byte enables.
// Optional alignment checking is enabled by DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic {
    IDLE,
    RD
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Unsupported codes fall through to word size.
  function automatic size_e f3_size(
    input logic       we,
    input logic [2:0] f3
  );
    size_e sz;
    sz = SZ_W;
    unique case (1'b1)
      f3 == F3_B,
      !we && f3 == F3_BU: sz = SZ_B;
      f3 == F3_H,
      !we && f3 == F3_HU: sz = SZ_H;
      default:            sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) ||
         (f3 == F3_W);
    if (!we)
      ok = ok || (f3 == F3_BU) ||
           (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_ctrl bus bundle: core request/response and SRAM port.
// slave = controller side, master = core/SRAM side.
interface dmem_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_en_o;
  logic [3:0]            mem_we_o;
  logic [ADDR_WIDTH-3:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i,
    input  req_funct3_i, req_addr_i,
    input  req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o,
    output mem_en_o, mem_we_o,
    output mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i,
    output req_funct3_i, req_addr_i,
    output req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o,
    input  mem_en_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load lane select and sign/zero extension of an SRAM word.
// Purely combinational.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    unique case (size)
      SZ_B:    data = {{24{~uns & b[7]}}, b};
      SZ_H:    data = {{16{~uns & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller between core LSU and a 1-cycle SRAM.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned/unsupported accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic  clk_i,
  input  logic  rst_i,
  dmem_if.slave bus
);

  state_e      state, state_nx;
  logic        ready, accept, fault;
  logic        we;
  logic [2:0]  f3;
  logic [1:0]  off;
  size_e       size;
  logic [3:0]  be;
  logic [31:0] wdata;

  size_e       size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] fmt;

  assign we   = bus.req_we_i;
  assign f3   = bus.req_funct3_i;
  assign off  = bus.req_addr_i[1:0];
  assign size = f3_size(we, f3);

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault = !f3_legal(we, f3) ||
                 (size == SZ_H && off[0]) ||
                 (size == SZ_W && off != 2'b00);
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        ready  = !rst_i;
        accept = ready && bus.req_valid_i;
        if (accept && !we && !fault)
          state_nx = RD;
      end
      RD:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    be    = BE_W;
    wdata = bus.req_wdata_i;
    unique case (size)
      SZ_B: begin
        be    = BE_B << off;
        wdata = {4{bus.req_wdata_i[7:0]}};
      end
      SZ_H: begin
        be    = off[1] ? (BE_H << 2) : BE_H;
        wdata = {2{bus.req_wdata_i[15:0]}};
      end
      default: begin
        be    = BE_W;
        wdata = bus.req_wdata_i;
      end
    endcase
  end

  assign bus.req_ready_o = ready;
  assign bus.mem_en_o    = accept && !fault;
  assign bus.mem_we_o    = (bus.mem_en_o && we) ?
                           be : BE_NONE;
  assign bus.mem_addr_o  =
    bus.req_addr_i[ADDR_WIDTH-1:2];
  assign bus.mem_wdata_o = wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      size_q <= SZ_W;
      uns_q  <= 1'b0;
      off_q  <= 2'b00;
    end else if (accept) begin
      size_q <= size;
      uns_q  <= f3[2];
      off_q  <= off;
    end
  end

  dmem_load_fmt u_fmt (
    .word (bus.mem_rdata_i),
    .size (size_q),
    .uns  (uns_q),
    .off  (off_q),
    .data (fmt)
  );

  // Stores and faults answer next cycle; loads answer from RD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      if (state == RD) begin
        bus.rsp_valid_o <= 1'b1;
        bus.rsp_rdata_o <= fmt;
        bus.rsp_err_o   <= 1'b0;
      end else if (accept && (we || fault)) begin
        bus.rsp_valid_o <= 1'b1;
        bus.rsp_rdata_o <= '0;
        bus.rsp_err_o   <= fault;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural SRAM.
// Response expectations are queued at issue and matched at the end.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  logic [31:0] sram [1024];

  dmem_if #(.ADDR_WIDTH(12)) bus ();

  dmem_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b])
          sram[bus.mem_addr_o][b*8 +: 8] <=
            bus.mem_wdata_o[b*8 +: 8];
      bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end
  end

  always @(negedge clk)
    if (bus.rsp_valid_o)
      obs_q.push_back('{bus.rsp_rdata_o,
                        bus.rsp_err_o, cyc});

  task automatic issue(
    input logic        we,
    input logic [2:0]  f3,
    input logic [11:0] addr,
    input logic [31:0] wd,
    input logic        exp_en,
    input logic [3:0]  exp_we,
    input logic [31:0] exp_wd,
    input logic        push,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input logic        rst_in_rd
  );
    logic [9:0] exp_wa;
    exp_wa = addr[11:2];
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready @%h: got %b want 1",
               addr, bus.req_ready_o);
    end
    checks++;
    if (bus.mem_en_o !== exp_en) begin
      errors++;
      $display("FAIL mem_en @%h: got %b want %b",
               addr, bus.mem_en_o, exp_en);
    end
    checks++;
    if (bus.mem_we_o !== exp_we) begin
      errors++;
      $display("FAIL mem_we @%h: got %b want %b",
               addr, bus.mem_we_o, exp_we);
    end
    if (exp_en) begin
      checks++;
      if (bus.mem_addr_o !== exp_wa) begin
        errors++;
        $display("FAIL mem_addr @%h: got %h want %h",
                 addr, bus.mem_addr_o, exp_wa);
      end
    end
    if (exp_en && we) begin
      checks++;
      if (bus.mem_wdata_o !== exp_wd) begin
        errors++;
        $display("FAIL mem_wdata @%h: got %h want %h",
                 addr, bus.mem_wdata_o, exp_wd);
      end
    end
    if (push)
      exp_q.push_back('{exp_rd, exp_err,
        cyc + ((we || !exp_en) ? 1 : 2)});
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    if (!we && exp_en) begin
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      #1;
      checks++;
      if (bus.req_ready_o !== 1'b0 ||
          bus.mem_en_o !== 1'b0) begin
        errors++;
        $display("FAIL rd_block: ready=%b en=%b want 0 0",
                 bus.req_ready_o, bus.mem_en_o);
      end
      if (rst_in_rd) rst = 1'b1;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = F3_W;
    bus.req_addr_i   = 12'h040;
    bus.req_wdata_i  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b0 ||
        bus.mem_en_o !== 1'b0 ||
        bus.mem_we_o !== 4'b0000) begin
      errors++;
      $display("FAIL rst_req: rdy=%b en=%b we=%b want 0 0 0",
               bus.req_ready_o, bus.mem_en_o,
               bus.mem_we_o);
    end
    checks++;
    if (bus.rsp_valid_o !== 1'b0 ||
        bus.rsp_rdata_o !== 32'h0 ||
        bus.rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp: v=%b d=%h e=%b want 0 0 0",
               bus.rsp_valid_o, bus.rsp_rdata_o,
               bus.rsp_err_o);
    end
    bus.req_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_exit_ready: got %b want 1",
               bus.req_ready_o);
    end
  endtask

  task automatic test_store_load();
    issue(1, F3_W, 12'h010, 32'hDEAD_BEEF, 1,
          4'b1111, 32'hDEAD_BEEF, 1, 0, 0, 0);
    issue(0, F3_W, 12'h010, 0, 1, 4'b0000, 0,
          1, 32'hDEAD_BEEF, 0, 0);
  endtask

  task automatic test_load_ext();
    issue(0, F3_B, 12'h013, 0, 1, 4'b0000, 0,
          1, 32'hFFFF_FFDE, 0, 0);
    issue(0, F3_BU, 12'h013, 0, 1, 4'b0000, 0,
          1, 32'h0000_00DE, 0, 0);
    issue(0, F3_H, 12'h012, 0, 1, 4'b0000, 0,
          1, 32'hFFFF_DEAD, 0, 0);
    issue(0, F3_HU, 12'h010, 0, 1, 4'b0000, 0,
          1, 32'h0000_BEEF, 0, 0);
    issue(0, F3_B, 12'h010, 0, 1, 4'b0000, 0,
          1, 32'hFFFF_FFEF, 0, 0);
  endtask

  task automatic test_sub_word_store();
    issue(1, F3_W, 12'h0A0, 32'h0, 1,
          4'b1111, 32'h0, 1, 0, 0, 0);
    issue(1, F3_B, 12'h0A1, 32'h1234_5678, 1,
          4'b0010, 32'h7878_7878, 1, 0, 0, 0);
    issue(1, F3_H, 12'h0A2, 32'hAAAA_8001, 1,
          4'b1100, 32'h8001_8001, 1, 0, 0, 0);
    issue(0, F3_W, 12'h0A0, 0, 1, 4'b0000, 0,
          1, 32'h8001_7800, 0, 0);
    issue(0, F3_H, 12'h0A2, 0, 1, 4'b0000, 0,
          1, 32'hFFFF_8001, 0, 0);
    issue(0, F3_BU, 12'h0A1, 0, 1, 4'b0000, 0,
          1, 32'h0000_0078, 0, 0);
  endtask

  task automatic test_back_to_back();
    issue(1, F3_W, 12'h100, 32'h1111_1111, 1,
          4'b1111, 32'h1111_1111, 1, 0, 0, 0);
    issue(1, F3_W, 12'h104, 32'h2222_2222, 1,
          4'b1111, 32'h2222_2222, 1, 0, 0, 0);
    issue(1, F3_W, 12'h108, 32'h3333_3333, 1,
          4'b1111, 32'h3333_3333, 1, 0, 0, 0);
    issue(0, F3_W, 12'h104, 0, 1, 4'b0000, 0,
          1, 32'h2222_2222, 0, 0);
    issue(0, F3_HU, 12'h10A, 0, 1, 4'b0000, 0,
          1, 32'h0000_3333, 0, 0);
  endtask

  task automatic test_reset_in_rd();
    issue(0, F3_W, 12'h010, 0, 1, 4'b0000, 0,
          0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_rst_rsp: got %b want 0",
               bus.rsp_valid_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1 ||
        bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_rst_exit: rdy=%b v=%b want 1 0",
               bus.req_ready_o, bus.rsp_valid_o);
    end
  endtask

  task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHECK_EN
    issue(0, F3_W, 12'h011, 0, 0, 4'b0000, 0,
          1, 32'h0, 1, 0);
    issue(1, F3_H, 12'h013, 32'h5555_5555, 0,
          4'b0000, 0, 1, 32'h0, 1, 0);
    issue(1, F3_BU, 12'h010, 32'h5555_5555, 0,
          4'b0000, 0, 1, 32'h0, 1, 0);
`else
    issue(0, F3_W, 12'h011, 0, 1, 4'b0000, 0,
          1, 32'hDEAD_BEEF, 0, 0);
    issue(0, F3_HU, 12'h013, 0, 1, 4'b0000, 0,
          1, 32'h0000_DEAD, 0, 0);
    issue(0, 3'b111, 12'h012, 0, 1, 4'b0000, 0,
          1, 32'hDEAD_BEEF, 0, 0);
`endif
    issue(0, F3_W, 12'h010, 0, 1, 4'b0000, 0,
          1, 32'hDEAD_BEEF, 0, 0);
  endtask

  task automatic test_responses();
    int n;
    for (int i = 0; i < 20; i++)
      if (obs_q.size() < exp_q.size())
        @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rsp_count: got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ?
        obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].rdata !== exp_q[i].rdata ||
          obs_q[i].err !== exp_q[i].err ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL rsp[%0d]: got %h/%b@%0d want %h/%b@%0d",
                 i, obs_q[i].rdata, obs_q[i].err,
                 obs_q[i].cyc, exp_q[i].rdata,
                 exp_q[i].err, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = F3_W;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    test_reset();
    test_store_load();
    test_load_ext();
    test_sub_word_store();
    test_back_to_back();
    test_reset_in_rd();
    test_misaligned();
    test_responses();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
